// File: rtl/i2c_touch_target.sv
// i2c_touch_target: I2C target emulating the MPR121 register subset used by
// the touch bring-up sequence (ECR at 0x5E, soft reset at 0x80, touch status
// at 0x00/0x01). Inputs are synchronised and glitch-filtered; SDA is only
// pulled low, never driven high, and SCL is never stretched.
// Optional feature: define I2C_TARGET_IRQ_EN to add the active-low irq_n output.
module i2c_touch_target #(
    parameter logic [6:0] DEV_ADDR   = 7'h5A,
    parameter int         FILTER_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    input  logic [11:0] touch_status,
    output logic [7:0]  ecr,
    output logic        soft_reset_pulse,
    output logic        busy
`ifdef I2C_TARGET_IRQ_EN
    ,
    output logic        irq_n
`endif
);

    localparam logic [3:0] FLT_MAX = 4'(FILTER_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic       r_scl_f, r_sda_f, r_scl_d, r_sda_d;
    logic [3:0] r_scl_cnt, r_sda_cnt;
    state_t     r_state;
    logic [3:0] r_bit;
    logic [6:0] r_shift;
    logic [7:0] r_ptr;
    logic [7:0] r_tx;
    logic [11:0] r_snap;
    logic       r_rw;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte;
    logic [7:0] w_rd_byte;

    // The target only ever pulls SDA low; the level comes from sda_t.
    assign sda_o = 1'b0;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl_i;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda_i;
            r_sda_s2 <= r_sda_s1;
        end
    end

    // Stability filters: a new level must persist FILTER_LEN cycles to be taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_f   <= 1'b1;
            r_sda_f   <= 1'b1;
            r_scl_cnt <= 4'd0;
            r_sda_cnt <= 4'd0;
        end else begin
            if (r_scl_s2 == r_scl_f) begin
                r_scl_cnt <= 4'd0;
            end else if (r_scl_cnt == FLT_MAX) begin
                r_scl_f   <= r_scl_s2;
                r_scl_cnt <= 4'd0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 4'd1;
            end
            if (r_sda_s2 == r_sda_f) begin
                r_sda_cnt <= 4'd0;
            end else if (r_sda_cnt == FLT_MAX) begin
                r_sda_f   <= r_sda_s2;
                r_sda_cnt <= 4'd0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 4'd1;
            end
        end
    end

    // Previous filtered levels for edge and bus-condition detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= r_scl_f;
            r_sda_d <= r_sda_f;
        end
    end

    assign w_scl_rise = r_scl_f & ~r_scl_d;
    assign w_scl_fall = ~r_scl_f & r_scl_d;
    assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
    assign w_byte     = {r_shift, r_sda_f};

    // Read map; touch bytes come from the per-transaction snapshot.
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_ptr)
            8'h00:   w_rd_byte = r_snap[7:0];
            8'h01:   w_rd_byte = {4'h0, r_snap[11:8]};
            8'h5E:   w_rd_byte = ecr;
            default: w_rd_byte = 8'h00;
        endcase
    end

    // Protocol FSM: bits sampled on SCL rise, SDA changed only on SCL fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_bit            <= 4'd0;
            r_shift          <= 7'd0;
            r_ptr            <= 8'h00;
            r_tx             <= 8'h00;
            r_snap           <= 12'h000;
            r_rw             <= 1'b0;
            sda_t            <= 1'b1;
            ecr              <= 8'h00;
            soft_reset_pulse <= 1'b0;
            busy             <= 1'b0;
        end else begin
            soft_reset_pulse <= 1'b0;
            if (w_stop) begin
                r_state <= S_IDLE;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
            end else if (w_start) begin
                r_state <= S_ADDR;
                r_bit   <= 4'd0;
                sda_t   <= 1'b1;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte[6:0];
                            r_bit   <= r_bit + 4'd1;
                            if (r_bit == 4'd7) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    busy    <= 1'b1;
                                    r_rw    <= w_byte[0];
                                    if (w_byte[0]) r_snap <= touch_status;
                                    r_state <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte[6:0];
                            r_bit   <= r_bit + 4'd1;
                            if (r_bit == 4'd7) begin
                                r_ptr   <= w_byte;
                                r_state <= S_PTR_ACK;
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte[6:0];
                            r_bit   <= r_bit + 4'd1;
                            if (r_bit == 4'd7) begin
                                if (r_ptr == 8'h5E) begin
                                    ecr <= w_byte;
                                end else if (r_ptr == 8'h80 && w_byte == 8'h63) begin
                                    soft_reset_pulse <= 1'b1;
                                    ecr              <= 8'h00;
                                end
                                r_ptr   <= r_ptr + 8'd1;
                                r_state <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        // r_bit==8: waiting to drive ACK; r_bit==9: ACK clocked.
                        if (w_scl_fall && r_bit == 4'd8) begin
                            sda_t <= 1'b0;
                        end else if (w_scl_rise) begin
                            r_bit <= 4'd9;
                        end else if (w_scl_fall && r_bit == 4'd9) begin
                            r_bit <= 4'd0;
                            if (r_state == S_ADDR_ACK && r_rw) begin
                                sda_t   <= w_rd_byte[7];
                                r_tx    <= {w_rd_byte[6:0], 1'b0};
                                r_state <= S_RDATA;
                            end else begin
                                sda_t   <= 1'b1;
                                r_state <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_rise) begin
                            r_bit <= r_bit + 4'd1;
                            if (r_bit == 4'd7) r_state <= S_RDATA_ACK;
                        end else if (w_scl_fall) begin
                            sda_t <= r_tx[7];
                            r_tx  <= {r_tx[6:0], 1'b0};
                        end
                    end
                    S_RDATA_ACK: begin
                        if (w_scl_fall && r_bit == 4'd8) begin
                            sda_t <= 1'b1;
                        end else if (w_scl_rise) begin
                            if (!r_sda_f) begin
                                r_ptr <= r_ptr + 8'd1;
                                r_bit <= 4'd9;
                            end else begin
                                r_state <= S_IGNORE;
                            end
                        end else if (w_scl_fall && r_bit == 4'd9) begin
                            r_bit   <= 4'd0;
                            sda_t   <= w_rd_byte[7];
                            r_tx    <= {w_rd_byte[6:0], 1'b0};
                            r_state <= S_RDATA;
                        end
                    end
                    S_IDLE, S_IGNORE: begin
                        r_bit <= r_bit;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef I2C_TARGET_IRQ_EN
    logic [11:0] r_irq_ref;
    logic        w_irq_clr;

    // Ninth SCL rise of a byte read from register 0x00 acknowledges the IRQ.
    assign w_irq_clr = (r_state == S_RDATA_ACK) && w_scl_rise &&
                       (r_bit == 4'd8) && (r_ptr == 8'h00);

    // Interrupt: asserted while touch status differs from the last reported value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_n     <= 1'b1;
            r_irq_ref <= 12'h000;
        end else if (w_irq_clr) begin
            r_irq_ref <= r_snap;
            irq_n     <= (touch_status == r_snap);
        end else if (touch_status != r_irq_ref) begin
            irq_n <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_touch_target.sv
`timescale 1ns/1ps
module tb_i2c_touch_target;
    localparam logic [6:0] DEV = 7'h5A;
    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tb_scl = 1'b1;
    logic        tb_sda = 1'b1;
    logic        sda_o, sda_t, soft_reset_pulse, busy;
    logic [11:0] touch_status = 12'h000;
    logic [7:0]  ecr;
    logic        w_bus;
`ifdef I2C_TARGET_IRQ_EN
    logic        irq_n;
`endif

    assign w_bus = tb_sda & (sda_t | sda_o);

    i2c_touch_target #(.DEV_ADDR(7'h5A), .FILTER_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(tb_scl), .sda_i(w_bus),
        .sda_o(sda_o), .sda_t(sda_t), .touch_status(touch_status),
        .ecr(ecr), .soft_reset_pulse(soft_reset_pulse), .busy(busy)
`ifdef I2C_TARGET_IRQ_EN
        , .irq_n(irq_n)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulse_cycles = 0;
    int low_cycles = 0;

    always @(posedge clk) begin
        if (soft_reset_pulse) pulse_cycles <= pulse_cycles + 1;
        if (!sda_t) low_cycles <= low_cycles + 1;
    end

    // Reference model of the register map
    logic [7:0] m_ecr = 8'h00;
    logic [7:0] m_ptr = 8'h00;
    int         m_pulses = 0;
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];
    logic       busy_seen;

    function automatic logic [7:0] m_read(input logic [7:0] a, input logic [11:0] s);
        if (a == 8'h00) return s[7:0];
        if (a == 8'h01) return {4'h0, s[11:8]};
        if (a == 8'h5E) return m_ecr;
        return 8'h00;
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [7:0] d);
        if (a == 8'h5E) m_ecr = d;
        if (a == 8'h80 && d == 8'h63) begin
            m_ecr = 8'h00;
            m_pulses++;
        end
    endtask

    // Bus-level helpers (timing in units of Q clk cycles)
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        if (tb_scl == 1'b0) begin
            wait_q(); tb_sda = 1'b1;
            wait_q(); tb_scl = 1'b1;
        end
        wait_q(); tb_sda = 1'b0;
        wait_q(); tb_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_q(); tb_sda = 1'b0;
        wait_q(); tb_scl = 1'b1;
        wait_q(); tb_sda = 1'b1;
        wait_q(); wait_q();
    endtask

    task automatic send_bit(input logic b);
        wait_q(); tb_sda = b;
        wait_q(); tb_scl = 1'b1;
        wait_q(); wait_q(); tb_scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wait_q(); tb_sda = 1'b1;
        wait_q(); tb_scl = 1'b1;
        wait_q(); b = w_bus;
        wait_q(); tb_scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(nack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nack);
    endtask

    task automatic i2c_wr(input logic [6:0] a, input bit stop, output int nacks);
        logic n;
        nacks = 0;
        bus_start();
        send_byte({a, 1'b0}, n);
        busy_seen = busy;
        if (n) nacks++;
        foreach (wr_q[i]) begin
            send_byte(wr_q[i], n);
            if (n) nacks++;
        end
        if (stop) bus_stop();
    endtask

    task automatic i2c_rd(input logic [6:0] a, input int nb, input bit chg,
                          input logic [11:0] nt, output logic an);
        logic [7:0] d;
        bus_start();
        send_byte({a, 1'b1}, an);
        busy_seen = busy;
        if (chg) touch_status = nt;
        rd_q.delete();
        for (int i = 0; i < nb; i++) begin
            recv_byte(i == nb - 1, d);
            rd_q.push_back(d);
        end
        bus_stop();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL reset_sda_t: got %b expected 1", sda_t); end
        checks++; if (sda_o !== 1'b0) begin errors++; $display("FAIL reset_sda_o: got %b expected 0", sda_o); end
        checks++; if (ecr !== 8'h00) begin errors++; $display("FAIL reset_ecr: got %h expected 00", ecr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (soft_reset_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", soft_reset_pulse); end
`ifdef I2C_TARGET_IRQ_EN
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b expected 1", irq_n); end
`endif
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL idle_sda_t: got %b expected 1", sda_t); end
    endtask

    task automatic test_ecr_write();
        int n; logic an;
        wr_q = '{8'h5E, 8'h8C};
        i2c_wr(DEV, 1, n);
        m_write(8'h5E, 8'h8C); m_ptr = 8'h5F;
        checks++; if (n !== 0) begin errors++; $display("FAIL ecr_wr_acks: got %0d nacks expected 0", n); end
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL ecr_wr_busy: got %b expected 1", busy_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ecr_wr_busy_stop: got %b expected 0", busy); end
        checks++; if (ecr !== m_ecr) begin errors++; $display("FAIL ecr_wr_value: got %h expected %h", ecr, m_ecr); end
        i2c_rd(DEV, 1, 0, 12'h000, an);
        checks++; if (an !== 1'b0) begin errors++; $display("FAIL ecr_rd_addr_ack: got %b expected 0", an); end
        checks++; if (rd_q[0] !== m_read(m_ptr, touch_status)) begin errors++; $display("FAIL ecr_rd_5F: got %h expected %h", rd_q[0], m_read(m_ptr, touch_status)); end
    endtask

    task automatic test_soft_reset();
        int n; int p0; logic [7:0] v;
        p0 = pulse_cycles;
        wr_q = '{8'h80, 8'h63};
        i2c_wr(DEV, 1, n);
        m_write(8'h80, 8'h63); m_ptr = 8'h81;
        checks++; if (n !== 0) begin errors++; $display("FAIL srst_acks: got %0d nacks expected 0", n); end
        checks++; if (pulse_cycles - p0 !== 1) begin errors++; $display("FAIL srst_pulse: got %0d cycles expected 1", pulse_cycles - p0); end
        checks++; if (ecr !== m_ecr) begin errors++; $display("FAIL srst_ecr: got %h expected %h", ecr, m_ecr); end
        v = 8'($urandom_range(1, 255));
        wr_q = '{8'h5E, v};
        i2c_wr(DEV, 1, n);
        m_write(8'h5E, v);
        v = 8'($urandom_range(0, 255));
        if (v == 8'h63) v = 8'h64;
        p0 = pulse_cycles;
        wr_q = '{8'h80, v};
        i2c_wr(DEV, 1, n);
        m_write(8'h80, v); m_ptr = 8'h81;
        checks++; if (pulse_cycles - p0 !== 0) begin errors++; $display("FAIL srst_bad_pulse: got %0d cycles expected 0", pulse_cycles - p0); end
        checks++; if (ecr !== m_ecr) begin errors++; $display("FAIL srst_bad_ecr: got %h expected %h", ecr, m_ecr); end
    endtask

    task automatic test_touch_read();
        int n; logic an; logic [11:0] ts, nt;
        for (int it = 0; it < 4; it++) begin
            ts = (it == 0) ? 12'hA5C : 12'($urandom);
            nt = (it == 0) ? 12'h000 : ~ts;
            touch_status = ts;
            wr_q = '{8'h00};
            i2c_wr(DEV, 0, n);
            i2c_rd(DEV, 2, 1, nt, an);
            m_ptr = 8'h01;
            checks++; if (rd_q[0] !== m_read(8'h00, ts)) begin errors++; $display("FAIL touch_b0[%0d]: got %h expected %h", it, rd_q[0], m_read(8'h00, ts)); end
            checks++; if (rd_q[1] !== m_read(8'h01, ts)) begin errors++; $display("FAIL touch_b1[%0d]: got %h expected %h", it, rd_q[1], m_read(8'h01, ts)); end
        end
    endtask

    task automatic test_wrong_addr();
        int n; int l0; logic [6:0] a;
        for (int it = 0; it < 3; it++) begin
            a = (it == 0) ? 7'h5B : 7'($urandom_range(0, 127));
            if (a == DEV) a = 7'h5B;
            l0 = low_cycles;
            wr_q = '{8'h5E, 8'($urandom)};
            i2c_wr(a, 1, n);
            checks++; if (n !== 3) begin errors++; $display("FAIL wrong_addr_nacks: got %0d expected 3", n); end
            checks++; if (low_cycles - l0 !== 0) begin errors++; $display("FAIL wrong_addr_sda_low: got %0d cycles expected 0", low_cycles - l0); end
            checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL wrong_addr_busy: got %b expected 0", busy_seen); end
            checks++; if (ecr !== m_ecr) begin errors++; $display("FAIL wrong_addr_ecr: got %h expected %h", ecr, m_ecr); end
        end
    endtask

    task automatic test_wrap();
        int n; logic an; logic [11:0] ts;
        ts = 12'($urandom);
        touch_status = ts;
        wr_q = '{8'hFF};
        i2c_wr(DEV, 0, n);
        i2c_rd(DEV, 2, 0, 12'h000, an);
        m_ptr = 8'h00;
        checks++; if (rd_q[0] !== m_read(8'hFF, ts)) begin errors++; $display("FAIL wrap_b0: got %h expected %h", rd_q[0], m_read(8'hFF, ts)); end
        checks++; if (rd_q[1] !== m_read(8'h00, ts)) begin errors++; $display("FAIL wrap_b1: got %h expected %h", rd_q[1], m_read(8'h00, ts)); end
    endtask

    task automatic test_back_to_back();
        int n; int p0; int nb; int op; logic an; logic [7:0] p, d; logic [11:0] ts;
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 6))
                0: p = 8'h00;  1: p = 8'h01;  2: p = 8'h5D;  3: p = 8'h5E;
                4: p = 8'h7F;  5: p = 8'hFE;  default: p = 8'($urandom);
            endcase
            op = $urandom_range(0, 2);
            nb = $urandom_range(1, 3);
            if (op == 0) begin
                wr_q = '{p};
                for (int i = 0; i < nb; i++) begin
                    d = ($urandom_range(0, 3) == 0) ? 8'h63 : 8'($urandom);
                    wr_q.push_back(d);
                end
                p0 = pulse_cycles; m_pulses = 0;
                i2c_wr(DEV, 1, n);
                m_ptr = p;
                for (int i = 1; i < wr_q.size(); i++) begin
                    m_write(m_ptr, wr_q[i]);
                    m_ptr = m_ptr + 8'd1;
                end
                checks++; if (n !== 0) begin errors++; $display("FAIL b2b_wr_nacks[%0d]: got %0d expected 0", it, n); end
                checks++; if (ecr !== m_ecr) begin errors++; $display("FAIL b2b_wr_ecr[%0d]: got %h expected %h", it, ecr, m_ecr); end
                checks++; if (pulse_cycles - p0 !== m_pulses) begin errors++; $display("FAIL b2b_wr_pulses[%0d]: got %0d expected %0d", it, pulse_cycles - p0, m_pulses); end
            end else begin
                ts = 12'($urandom);
                touch_status = ts;
                if (op == 1) begin
                    wr_q = '{p};
                    i2c_wr(DEV, 0, n);
                    m_ptr = p;
                end
                i2c_rd(DEV, nb, 1, 12'($urandom), an);
                checks++; if (an !== 1'b0) begin errors++; $display("FAIL b2b_rd_addr_ack[%0d]: got %b expected 0", it, an); end
                for (int i = 0; i < nb; i++) begin
                    d = m_read(m_ptr + 8'(i), ts);
                    checks++; if (rd_q[i] !== d) begin errors++; $display("FAIL b2b_rd[%0d.%0d]: got %h expected %h", it, i, rd_q[i], d); end
                end
                m_ptr = m_ptr + 8'(nb - 1);
            end
        end
    endtask

    task automatic test_reset_midread();
        int n; logic an; logic [7:0] v; logic [11:0] ts;
        v = 8'($urandom_range(1, 127));
        wr_q = '{8'h5E, v};
        i2c_wr(DEV, 1, n);
        m_write(8'h5E, v);
        wr_q = '{8'h5E};
        i2c_wr(DEV, 0, n);
        bus_start();
        send_byte({DEV, 1'b1}, an);
        wait_q();
        checks++; if (sda_t !== 1'b0) begin errors++; $display("FAIL midread_drive: got %b expected 0", sda_t); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (sda_t !== 1'b1) begin errors++; $display("FAIL midread_release: got %b expected 1", sda_t); end
        checks++; if (ecr !== 8'h00) begin errors++; $display("FAIL midread_ecr: got %h expected 00", ecr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_busy: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ecr = 8'h00; m_ptr = 8'h00;
        bus_stop();
        ts = 12'($urandom);
        touch_status = ts;
        i2c_rd(DEV, 1, 0, 12'h000, an);
        checks++; if (rd_q[0] !== m_read(m_ptr, ts)) begin errors++; $display("FAIL after_reset_ptr: got %h expected %h", rd_q[0], m_read(m_ptr, ts)); end
    endtask

`ifdef I2C_TARGET_IRQ_EN
    task automatic test_irq();
        int n; logic an;
        touch_status = 12'h000;
        wr_q = '{8'h00};
        i2c_wr(DEV, 0, n);
        i2c_rd(DEV, 1, 0, 12'h000, an);
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_idle: got %b expected 1", irq_n); end
        touch_status = 12'h008;
        repeat (2) @(negedge clk);
        checks++; if (irq_n !== 1'b0) begin errors++; $display("FAIL irq_assert: got %b expected 0", irq_n); end
        wr_q = '{8'h00};
        i2c_wr(DEV, 0, n);
        i2c_rd(DEV, 1, 0, 12'h000, an);
        checks++; if (rd_q[0] !== 8'h08) begin errors++; $display("FAIL irq_read: got %h expected 08", rd_q[0]); end
        checks++; if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_clear: got %b expected 1", irq_n); end
        m_ptr = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_ecr_write();
        test_soft_reset();
        test_touch_read();
        test_wrong_addr();
        test_wrap();
        test_back_to_back();
        test_reset_midread();
`ifdef I2C_TARGET_IRQ_EN
        test_irq();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_touch_target.md
Name: i2c_touch_target

Overview:
- I2C target (responder) that emulates the subset of the MPR121 capacitive-touch register map driven by our i2c_master bring-up sequence.
- It is the other end of that bus: it answers at a programmable 7-bit address, holds ECR and soft-reset state, and returns live touch status.
- Used in simulation as the bus model behind the top-level touch FSM, and on FPGA as a stand-in touch controller.
- Open-drain signalling matches i2c_master: scl_i/sda_i inputs, sda_o/sda_t outputs. The block never stretches SCL.

Parameters:
- DEV_ADDR, 7'h5A, 7-bit target address matched after START.
- FILTER_LEN, 4, clk cycles an input level must remain stable before the filtered SCL/SDA value changes (1..15).

Ports:
- clk  in  1  system clock (27 MHz in top)
- rst_n  in  1  asynchronous active-low reset
- scl_i  in  1  SCL pin input
- sda_i  in  1  SDA pin input
- sda_o  out  1  SDA output value (always 0 when driven)
- sda_t  out  1  SDA tristate enable; 1 = released
- touch_status  in  12  live electrode status; bit n = electrode n touched
- ecr  out  8  ECR register (0x5E) contents
- soft_reset_pulse  out  1  one-cycle pulse on a valid soft reset
- busy  out  1  high from address match until STOP

Behaviour:
- Reset values (while rst_n=0, asynchronous): sda_o=0, sda_t=1, ecr=0x00, soft_reset_pulse=0, busy=0, reg pointer=0x00, state=IDLE.
- Input conditioning: 2-FF synchroniser on scl_i and sda_i, then a stability filter of FILTER_LEN cycles. All edges are detected on the filtered signals.
- Bus conditions (filtered):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are recognised in every state.
  - START (including repeated START) goes to ADDR with bit counter 0.
  - STOP goes to IDLE, releases SDA and clears busy.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- Sampling and driving:
  - SDA is sampled on the filtered SCL rising edge, MSB first.
  - SDA is changed only on the filtered SCL falling edge, so it is stable through each SCL high phase.
- ADDR:
  - Shift in 8 bits.
  - If [7:1]==DEV_ADDR: drive ACK (sda_t=0) for the 9th clock and set busy.
  - Otherwise: IGNORE, with SDA released until the next START or STOP.
  - On R/W=0, go to PTR via ADDR_ACK.
  - On R/W=1, capture snapshot = touch_status on the 8th rising edge, then go to RDATA.
- PTR: first written byte loads the reg pointer; always ACKed; then WDATA.
- WDATA:
  - Each byte is ACKed and written to the register at the pointer; the pointer then increments.
  - Writes take effect on the 8th SCL rise.
  - Register writes:
    - 0x5E: writes ecr.
    - 0x80 with value 0x63: pulses soft_reset_pulse for one clk and sets ecr=0x00.
    - 0x80 with any other value: ignored.
    - Any other address: byte ignored but still ACKed.
- RDATA:
  - Drive the byte at the pointer, MSB first. A 0 bit sets sda_t=0; a 1 bit sets sda_t=1.
  - After 8 bits release SDA and sample the controller ACK on the 9th rise.
  - ACK (0): pointer increments and the next byte loads.
  - NACK (1): IGNORE.
- Read map:
  - 0x00 = snapshot[7:0]
  - 0x01 = {4'h0, snapshot[11:8]}
  - 0x5E = ecr
  - all others = 0x00
  - The snapshot is taken once per read transaction, so multi-byte reads are coherent.
- Pointer: 8-bit, wraps 0xFF→0x00; retained across transactions, so write-pointer then repeated-START read works.
- rst_n assertion mid-transfer releases SDA immediately. After reset the block ignores the bus until the next START.
- A START or STOP arriving mid-byte aborts the byte. A partial write is discarded.

Optional Feature:
- I2C_TARGET_IRQ_EN: adds output irq_n (1 bit, reset 1).
- With the macro: irq_n goes low one clk after touch_status differs from the value latched at the last read of register 0x00. irq_n returns high on the 9th SCL rise of a read byte from 0x00. A change during that read keeps irq_n low.
- Without the macro: the port and its logic are absent.

Test Plan:
- Write 0x5A/W, 0x80, 0x63, STOP with ecr=0x8C beforehand → all three bytes ACKed, soft_reset_pulse high exactly 1 clk, ecr=0x00.
- Write 0x5A/W, 0x5E, 0x8C, STOP → ecr=0x8C; then read 0x5A/R one byte (pointer now 0x5F) → returns 0x00.
- touch_status=12'hA5C; write pointer 0x00, repeated START, read 2 bytes ACK/NACK → bytes 0x5C and 0x0A. touch_status changing to 0x000 after the address byte does not alter byte 2.
- Address 0x5B/W → address byte NACKed, sda_t stays 1 for the whole transaction, busy=0, ecr unchanged.
- Pointer 0xFF, read 2 bytes → second byte comes from 0x00 (wrap). Also: assert rst_n low mid-read → sda_t=1 within the same cycle, ecr=0x00.
- With I2C_TARGET_IRQ_EN: touch_status 0x000→0x008 → irq_n low; read register 0x00 → returns 0x08 and irq_n high after the byte's ACK clock.
